fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetch requests, collects in-order responses
// into a small FIFO for decode, and flushes on redirect by dropping stale responses.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             deq_ready,
    output logic             deq_valid,
    output logic [WIDTH-1:0] deq_instr,
    output logic [WIDTH-1:0] deq_pc,
    output logic [WIDTH-1:0] deq_pcplus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] pc_q [DEPTH];

    logic [CW-1:0] occupancy;
    logic          req_fire;
    logic          deq_fire;
    logic          wr_en;

    // Reserving a slot per outstanding request guarantees every response has room.
    always_comb begin
        occupancy   = count_q + inflight_q;
        inst_req    = !rst && (occupancy < CW'(DEPTH));
        inst_addr   = fetch_pc_q;
        req_fire    = inst_req && inst_addr_ok;
        deq_valid   = !rst && (count_q != '0);
        deq_fire    = deq_valid && deq_ready;
        deq_instr   = instr_q[rd_ptr_q];
        deq_pc      = pc_q[rd_ptr_q];
        deq_pcplus4 = pc_q[rd_ptr_q] + WIDTH'(4);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(inst_data_ok);
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_en      = 1'b0;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            ret_pc_d   = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            discard_d  = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(4);
            end
            if (inst_data_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    wr_en    = 1'b1;
                    ret_pc_d = ret_pc_q + WIDTH'(4);
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (wr_en) begin
                instr_q[wr_ptr_q] <= inst_rdata;
                pc_q[wr_ptr_q]    <= ret_pc_q;
            end
        end
    end

endmodule
